// File: rtl/pma_region_table_if.sv
// Configuration and lookup bundle for pma_region_table.
// The slave modport is the table side; the master modport is the requester side.
interface pma_region_table_if #(
    parameter int unsigned AddrWidth     = 64,
    parameter int unsigned NrLookupPorts = 2
);
    logic                                    cfg_req_i;
    logic                                    cfg_we_i;
    logic [3:0]                              cfg_idx_i;
    logic [1:0]                              cfg_field_i;
    logic [AddrWidth-1:0]                    cfg_wdata_i;
    logic                                    cfg_gnt_o;
    logic                                    cfg_rvalid_o;
    logic [AddrWidth-1:0]                    cfg_rdata_o;
    logic                                    cfg_err_o;

    logic [NrLookupPorts-1:0]                lookup_valid_i;
    logic [NrLookupPorts-1:0][AddrWidth-1:0] lookup_addr_i;
    logic [NrLookupPorts-1:0]                lookup_valid_o;
    logic [NrLookupPorts-1:0]                lookup_hit_o;
    logic [NrLookupPorts-1:0][2:0]           lookup_attr_o;
    logic [NrLookupPorts-1:0][3:0]           lookup_idx_o;

    modport master (
        output cfg_req_i, cfg_we_i, cfg_idx_i, cfg_field_i, cfg_wdata_i,
        input  cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
        output lookup_valid_i, lookup_addr_i,
        input  lookup_valid_o, lookup_hit_o, lookup_attr_o, lookup_idx_o
    );

    modport slave (
        input  cfg_req_i, cfg_we_i, cfg_idx_i, cfg_field_i, cfg_wdata_i,
        output cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
        input  lookup_valid_i, lookup_addr_i,
        output lookup_valid_o, lookup_hit_o, lookup_attr_o, lookup_idx_o
    );
endinterface

// File: rtl/pma_region_table.sv
// Programmable PMA region table: shadow/active entries with atomic commit,
// per-entry lock, and NrLookupPorts registered lookup ports.
module pma_region_table #(
    parameter int unsigned                       NrRules       = 4,
    parameter int unsigned                       AddrWidth     = 64,
    parameter int unsigned                       NrLookupPorts = 2,
    parameter logic [NrRules-1:0][AddrWidth-1:0] RstBase       = '0,
    parameter logic [NrRules-1:0][AddrWidth-1:0] RstLength     = '0,
    parameter logic [NrRules-1:0][3:0]           RstAttr       = '0,
    parameter logic [2:0]                        DefaultAttr   = 3'b010
) (
    input logic               clk_i,
    input logic               rst_i,
    pma_region_table_if.slave bus
);
    localparam int unsigned IdxW = (NrRules > 1) ? $clog2(NrRules) : 1;
    localparam int unsigned SumW = AddrWidth + 1;

    typedef struct packed {
        logic [AddrWidth-1:0] base;
        logic [AddrWidth-1:0] length;
        logic [3:0]           attr;   // {lock, exec, nonidem, cached}
    } entry_t;

    entry_t active [NrRules];
    entry_t shadow [NrRules];
    logic   dirty;

    logic                 idx_ok;
    logic [IdxW-1:0]      sel;
    logic                 sel_locked;
    entry_t               sel_shadow;
    logic                 commit;
    logic                 wr_ok;
    logic [AddrWidth-1:0] rd_data;
    logic                 rd_err;

    logic [NrLookupPorts-1:0]      hit_c;
    logic [NrLookupPorts-1:0][2:0] attr_c;
    logic [NrLookupPorts-1:0][3:0] idx_c;

    // End of region is formed one bit wider so the top of the address space does not wrap.
    function automatic logic entry_match(input entry_t e, input logic [AddrWidth-1:0] a);
        logic [SumW-1:0] limit;
        limit = {1'b0, e.base} + {1'b0, e.length};
        return (e.length != '0) && (a >= e.base) && ({1'b0, a} < limit);
    endfunction

    assign bus.cfg_gnt_o = bus.cfg_req_i;

    // Config access decode and read mux.
    always_comb begin
        idx_ok     = {1'b0, bus.cfg_idx_i} < 5'(NrRules);
        sel        = IdxW'(bus.cfg_idx_i);
        sel_shadow = shadow[sel];
        sel_locked = active[sel].attr[3];
        commit     = bus.cfg_req_i && bus.cfg_we_i && (bus.cfg_field_i == 2'd3);
        wr_ok      = bus.cfg_req_i && bus.cfg_we_i && (bus.cfg_field_i != 2'd3)
                     && idx_ok && !sel_locked;
        rd_data    = '0;
        rd_err     = 1'b0;
        if (bus.cfg_req_i) begin
            if (bus.cfg_we_i) begin
                if (bus.cfg_field_i != 2'd3 && (!idx_ok || sel_locked)) begin
                    rd_err = 1'b1;
                end
            end else if (bus.cfg_field_i == 2'd3) begin
                rd_data = AddrWidth'({dirty, 5'(NrRules)});
            end else if (!idx_ok) begin
                rd_err = 1'b1;
            end else begin
                case (bus.cfg_field_i)
                    2'd0:    rd_data = sel_shadow.base;
                    2'd1:    rd_data = sel_shadow.length;
                    default: rd_data = AddrWidth'(sel_shadow.attr);
                endcase
            end
        end
    end

    // Table storage, dirty tracking and config response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NrRules; i++) begin
                active[i] <= entry_t'{base: RstBase[i], length: RstLength[i], attr: RstAttr[i]};
                shadow[i] <= entry_t'{base: RstBase[i], length: RstLength[i], attr: RstAttr[i]};
            end
            dirty            <= 1'b0;
            bus.cfg_rvalid_o <= 1'b0;
            bus.cfg_rdata_o  <= '0;
            bus.cfg_err_o    <= 1'b0;
        end else begin
            bus.cfg_rvalid_o <= bus.cfg_req_i;
            bus.cfg_rdata_o  <= rd_data;
            bus.cfg_err_o    <= rd_err;
            if (commit) begin
                for (int unsigned i = 0; i < NrRules; i++) begin
                    active[i] <= shadow[i];
                end
                dirty <= 1'b0;
            end else if (wr_ok) begin
                dirty <= 1'b1;
                case (bus.cfg_field_i)
                    2'd0:    shadow[sel].base   <= bus.cfg_wdata_i;
                    2'd1:    shadow[sel].length <= bus.cfg_wdata_i;
                    default: shadow[sel].attr   <= bus.cfg_wdata_i[3:0];
                endcase
            end
        end
    end

    // Priority match per port; scanning downwards lets the lowest index win.
    always_comb begin
        for (int unsigned p = 0; p < NrLookupPorts; p++) begin
            hit_c[p]  = 1'b0;
            attr_c[p] = DefaultAttr;
            idx_c[p]  = '0;
            for (int i = int'(NrRules) - 1; i >= 0; i--) begin
                if (entry_match(active[i], bus.lookup_addr_i[p])) begin
                    hit_c[p]  = 1'b1;
                    attr_c[p] = active[i].attr[2:0];
                    idx_c[p]  = 4'(i);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.lookup_valid_o <= '0;
            bus.lookup_hit_o   <= '0;
            bus.lookup_attr_o  <= '0;
            bus.lookup_idx_o   <= '0;
        end else begin
            bus.lookup_valid_o <= bus.lookup_valid_i;
            bus.lookup_hit_o   <= hit_c;
            bus.lookup_attr_o  <= attr_c;
            bus.lookup_idx_o   <= idx_c;
        end
    end

endmodule

// File: tb/tb_pma_region_table.sv
// Directed and randomized checks of pma_region_table against a behavioural table model.
module tb_pma_region_table;
    localparam int unsigned NR = 4;
    localparam int unsigned AW = 64;
    localparam int unsigned NP = 2;
    localparam logic [NR-1:0][AW-1:0] RB = {64'h0, 64'h0, 64'h0, 64'h8000_0000};
    localparam logic [NR-1:0][AW-1:0] RL = {64'h0, 64'h0, 64'h0, 64'h4000_0000};
    localparam logic [NR-1:0][3:0]    RA = {4'h0, 4'h0, 4'h0, 4'b0011};
    localparam logic [2:0]            DEF = 3'b010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    pma_region_table_if #(.AddrWidth(AW), .NrLookupPorts(NP)) bus ();

    pma_region_table #(
        .NrRules(NR), .AddrWidth(AW), .NrLookupPorts(NP),
        .RstBase(RB), .RstLength(RL), .RstAttr(RA), .DefaultAttr(DEF)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [AW-1:0] a_base [NR];
    logic [AW-1:0] a_len  [NR];
    logic [3:0]    a_attr [NR];
    logic [AW-1:0] s_base [NR];
    logic [AW-1:0] s_len  [NR];
    logic [3:0]    s_attr [NR];
    logic          m_dirty;

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(NR); i++) begin
            a_base[i] = RB[i]; a_len[i] = RL[i]; a_attr[i] = RA[i];
            s_base[i] = RB[i]; s_len[i] = RL[i]; s_attr[i] = RA[i];
        end
        m_dirty = 1'b0;
    endtask

    // First enabled region (in index order) whose offset from base is below its length.
    task automatic ref_lookup(input logic [AW-1:0] a, output logic hit,
                              output logic [2:0] attr, output logic [3:0] idx);
        hit = 1'b0; attr = DEF; idx = 4'd0;
        for (int i = 0; i < int'(NR); i++) begin
            if (!hit && a_len[i] != 0 && a >= a_base[i] && (a - a_base[i]) < a_len[i]) begin
                hit = 1'b1; attr = a_attr[i][2:0]; idx = 4'(i);
            end
        end
    endtask

    task automatic ref_cfg(input logic we, input logic [3:0] idx, input logic [1:0] fld,
                           input logic [AW-1:0] wd, output logic [AW-1:0] rdata, output logic err);
        rdata = '0; err = 1'b0;
        if (we) begin
            if (fld == 2'd3) begin
                for (int i = 0; i < int'(NR); i++) begin
                    a_base[i] = s_base[i]; a_len[i] = s_len[i]; a_attr[i] = s_attr[i];
                end
                m_dirty = 1'b0;
            end else if (idx >= NR) begin
                err = 1'b1;
            end else if (a_attr[idx][3]) begin
                err = 1'b1;
            end else begin
                if (fld == 2'd0) s_base[idx] = wd;
                else if (fld == 2'd1) s_len[idx] = wd;
                else s_attr[idx] = wd[3:0];
                m_dirty = 1'b1;
            end
        end else if (fld == 2'd3) begin
            rdata = {58'b0, m_dirty, 5'(NR)};
        end else if (idx >= NR) begin
            err = 1'b1;
        end else begin
            if (fld == 2'd0) rdata = s_base[idx];
            else if (fld == 2'd1) rdata = s_len[idx];
            else rdata = {60'b0, s_attr[idx]};
        end
    endtask

    // One clock: drive config and lookups, predict, step, compare every registered output.
    task automatic cyc(input logic rq, input logic we, input logic [3:0] idx, input logic [1:0] fld,
                       input logic [AW-1:0] wd, input logic [NP-1:0] lv,
                       input logic [AW-1:0] la0, input logic [AW-1:0] la1);
        logic          eh [NP];
        logic [2:0]    ea [NP];
        logic [3:0]    ei [NP];
        logic [AW-1:0] la [NP];
        logic [AW-1:0] erd;
        logic          eerr;
        la[0] = la0; la[1] = la1;
        bus.cfg_req_i = rq; bus.cfg_we_i = we; bus.cfg_idx_i = idx;
        bus.cfg_field_i = fld; bus.cfg_wdata_i = wd;
        bus.lookup_valid_i = lv;
        bus.lookup_addr_i[0] = la0; bus.lookup_addr_i[1] = la1;
        for (int p = 0; p < int'(NP); p++) ref_lookup(la[p], eh[p], ea[p], ei[p]);
        erd = '0; eerr = 1'b0;
        if (rst) model_reset();
        else if (rq) ref_cfg(we, idx, fld, wd, erd, eerr);
        #1;
        chk("cfg_gnt", AW'(bus.cfg_gnt_o), AW'(rq));
        @(posedge clk); #1;
        if (rst) begin
            chk("rst_cfg_rvalid", AW'(bus.cfg_rvalid_o), '0);
            chk("rst_lookup_valid", AW'(bus.lookup_valid_o), '0);
        end else begin
            chk("cfg_rvalid", AW'(bus.cfg_rvalid_o), AW'(rq));
            if (rq) begin
                chk($sformatf("cfg_rdata we=%0d idx=%0d fld=%0d", we, idx, fld), bus.cfg_rdata_o, erd);
                chk($sformatf("cfg_err we=%0d idx=%0d fld=%0d", we, idx, fld), AW'(bus.cfg_err_o), AW'(eerr));
            end
            for (int p = 0; p < int'(NP); p++) begin
                chk($sformatf("lk_valid%0d", p), AW'(bus.lookup_valid_o[p]), AW'(lv[p]));
                if (lv[p]) begin
                    chk($sformatf("lk_hit%0d a=%h", p, la[p]), AW'(bus.lookup_hit_o[p]), AW'(eh[p]));
                    chk($sformatf("lk_attr%0d a=%h", p, la[p]), AW'(bus.lookup_attr_o[p]), AW'(ea[p]));
                    chk($sformatf("lk_idx%0d a=%h", p, la[p]), AW'(bus.lookup_idx_o[p]), AW'(ei[p]));
                end
            end
        end
    endtask

    task automatic wr(input logic [3:0] idx, input logic [1:0] fld, input logic [AW-1:0] wd);
        cyc(1'b1, 1'b1, idx, fld, wd, 2'b00, '0, '0);
    endtask

    task automatic rd(input logic [3:0] idx, input logic [1:0] fld);
        cyc(1'b1, 1'b0, idx, fld, '0, 2'b00, '0, '0);
    endtask

    task automatic look(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        cyc(1'b0, 1'b0, 4'd0, 2'd0, '0, 2'b11, a0, a1);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return AW'($urandom_range(0, 32'h2_0000));
            1:       return 64'h7FFF_F000 + AW'($urandom_range(0, 32'h2000));
            2:       return 64'hFFFF_FFFF_FFFF_E000 + AW'($urandom_range(0, 32'h1FFF));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        bus.cfg_req_i = 1'b0; bus.cfg_we_i = 1'b0; bus.cfg_idx_i = '0;
        bus.cfg_field_i = '0; bus.cfg_wdata_i = '0;
        bus.lookup_valid_i = '0; bus.lookup_addr_i = '0;
        model_reset();

        // Reset state
        rst = 1'b1;
        cyc(1'b0, 1'b0, 4'd0, 2'd0, '0, 2'b11, 64'h8000_1000, '0);
        chk("rst_hit", AW'(bus.lookup_hit_o), '0);
        chk("rst_rdata", bus.cfg_rdata_o, '0);
        chk("rst_err", AW'(bus.cfg_err_o), '0);
        rst = 1'b0;
        for (int i = 0; i < int'(NR); i++)
            for (int f = 0; f < 3; f++) rd(4'(i), 2'(f));
        rd(4'd0, 2'd3);
        chk("status_after_reset", bus.cfg_rdata_o, 64'h04);

        // Reset-configured region
        look(64'h8000_1000, 64'h7FFF_FFFF);
        chk("tp1_hit0", AW'(bus.lookup_hit_o[0]), 64'd1);
        chk("tp1_attr0", AW'(bus.lookup_attr_o[0]), 64'b011);
        chk("tp1_idx0", AW'(bus.lookup_idx_o[0]), 64'd0);
        chk("tp1_hit1", AW'(bus.lookup_hit_o[1]), 64'd0);
        chk("tp1_attr1", AW'(bus.lookup_attr_o[1]), 64'b010);

        // Overlapping entries, lowest index wins
        wr(4'd1, 2'd0, 64'h1000); wr(4'd1, 2'd1, 64'h1000); wr(4'd1, 2'd2, 64'b0100);
        wr(4'd2, 2'd0, 64'h0);    wr(4'd2, 2'd1, 64'h1_0000); wr(4'd2, 2'd2, 64'b0001);
        wr(4'd0, 2'd3, '0);
        look(64'h1800, 64'h3000);
        chk("tp2_idx0", AW'(bus.lookup_idx_o[0]), 64'd1);
        chk("tp2_attr0", AW'(bus.lookup_attr_o[0]), 64'b100);
        chk("tp2_idx1", AW'(bus.lookup_idx_o[1]), 64'd2);
        chk("tp2_attr1", AW'(bus.lookup_attr_o[1]), 64'b001);

        // Shadow write is invisible until commit; commit cycle still sees old set
        wr(4'd0, 2'd1, 64'h100);
        look(64'h8000_1000, 64'h8000_00FF);
        chk("tp3_pre_hit", AW'(bus.lookup_hit_o[0]), 64'd1);
        rd(4'd0, 2'd3);
        chk("tp3_dirty", bus.cfg_rdata_o, 64'h24);
        cyc(1'b1, 1'b1, 4'd0, 2'd3, '0, 2'b11, 64'h8000_1000, 64'h8000_1000);
        chk("tp3_commit_cycle_hit", AW'(bus.lookup_hit_o[0]), 64'd1);
        look(64'h8000_1000, 64'h8000_00FF);
        chk("tp3_post_hit0", AW'(bus.lookup_hit_o[0]), 64'd0);
        chk("tp3_post_hit1", AW'(bus.lookup_hit_o[1]), 64'd1);
        rd(4'd0, 2'd3);
        chk("tp3_clean", bus.cfg_rdata_o, 64'h04);
        wr(4'd1, 2'd0, 64'h2000);
        rd(4'd1, 2'd0);
        chk("wr_then_rd", bus.cfg_rdata_o, 64'h2000);
        wr(4'd5, 2'd0, 64'h1234);
        chk("wr_bad_idx_err", AW'(bus.cfg_err_o), 64'd1);
        rd(4'd7, 2'd1);
        chk("rd_bad_idx_err", AW'(bus.cfg_err_o), 64'd1);

        // Lock
        wr(4'd3, 2'd2, 64'b1001);
        wr(4'd0, 2'd3, '0);
        wr(4'd3, 2'd0, 64'h5000);
        chk("tp4_locked_err", AW'(bus.cfg_err_o), 64'd1);
        rd(4'd3, 2'd0);
        chk("tp4_base_kept", bus.cfg_rdata_o, 64'h0);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 4'd0, 2'd0, '0, 2'b11, 64'h1800, 64'h3000);
        rst = 1'b0;
        wr(4'd3, 2'd0, 64'hFFFF_FFFF_FFFF_F000);
        chk("tp4_unlocked_err", AW'(bus.cfg_err_o), 64'd0);

        // Top of the address space, no wrap
        wr(4'd3, 2'd1, 64'h1000);
        wr(4'd0, 2'd3, '0);
        look(64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        chk("tp5_top_hit", AW'(bus.lookup_hit_o[0]), 64'd1);
        chk("tp5_top_idx", AW'(bus.lookup_idx_o[0]), 64'd3);
        chk("tp5_zero_hit", AW'(bus.lookup_hit_o[1]), 64'd0);
        look(64'hFFFF_FFFF_FFFF_EFFF, 64'hFFFF_FFFF_FFFF_F000);

        // Random multi-port traffic with occasional config and a mid-stream reset
        for (int c = 0; c < 400; c++) begin
            logic          rq;
            logic          we;
            logic [1:0]    fld;
            logic [AW-1:0] wd;
            rq  = ($urandom_range(0, 7) == 0);
            we  = $urandom_range(0, 1) == 1;
            fld = 2'($urandom_range(0, 3));
            wd  = (fld == 2'd1) ? AW'($urandom_range(0, 32'h3_0000)) : rand_addr();
            rst = (c == 200);
            cyc(rq, we, 4'($urandom_range(0, 5)), fld, wd, 2'($urandom_range(0, 3)),
                rand_addr(), rand_addr());
        end
        rst = 1'b1;
        cyc(1'b0, 1'b0, 4'd0, 2'd0, '0, 2'b11, 64'h8000_0000, 64'h1000);
        rst = 1'b0;
        for (int i = 0; i < int'(NR); i++) begin
            rd(4'(i), 2'd0); chk($sformatf("final_base%0d", i), bus.cfg_rdata_o, RB[i]);
            rd(4'(i), 2'd1); chk($sformatf("final_len%0d", i), bus.cfg_rdata_o, RL[i]);
            rd(4'(i), 2'd2); chk($sformatf("final_attr%0d", i), bus.cfg_rdata_o, AW'(RA[i]));
        end
        rd(4'd0, 2'd3);
        chk("final_status", bus.cfg_rdata_o, 64'h04);
        look(64'h8000_0000, 64'hC000_0000);
        chk("final_hit0", AW'(bus.lookup_hit_o[0]), 64'd1);
        chk("final_hit1", AW'(bus.lookup_hit_o[1]), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pma_region_table.md
# pma_region_table

Programmable physical-memory-attribute table for the CVA6 memory subsystem. It replaces the fixed cached, non-idempotent and execute region rules with run-time programmable entries, which reset to the configuration values. Entries are reprogrammed through a shadow copy and committed atomically. Each entry can be locked until the next reset. NrLookupPorts independent, registered lookup ports serve fetch, load/store and the PTW in parallel.

## Interface
- NrRules, 4: number of region entries (1..16).
- AddrWidth, 64: physical address width; also the width of the base and length fields.
- NrLookupPorts, 2: number of parallel lookup channels.
- RstBase, all 0: array[NrRules] of reset base addresses.
- RstLength, all 0: array[NrRules] of reset lengths; 0 = entry disabled.
- RstAttr, all 0: array[NrRules] of reset 4-bit attributes {lock, exec, nonidem, cached}.
- DefaultAttr, 3'b010: attribute {exec, nonidem, cached} returned on a miss.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- cfg_req_i  in  1  configuration access request.
- cfg_we_i  in  1  1 = write, 0 = read.
- cfg_idx_i  in  4  entry index.
- cfg_field_i  in  2  0 = base, 1 = length, 2 = attr, 3 = commit/status.
- cfg_wdata_i  in  AddrWidth  write data.
- cfg_gnt_o  out  1  access accepted; equals cfg_req_i.
- cfg_rvalid_o  out  1  response valid, one cycle after grant.
- cfg_rdata_o  out  AddrWidth  read data; 0 for writes.
- cfg_err_o  out  1  error flag, qualified by cfg_rvalid_o.
- lookup_valid_i  in  NrLookupPorts  per-port request.
- lookup_addr_i  in  NrLookupPorts×AddrWidth  per-port address.
- lookup_valid_o  out  NrLookupPorts  per-port result valid.
- lookup_hit_o  out  NrLookupPorts  an enabled entry matched.
- lookup_attr_o  out  NrLookupPorts×3  {exec, nonidem, cached}.
- lookup_idx_o  out  NrLookupPorts×4  matching entry index; 0 on a miss.

## Operation
- Storage:
  - active[i] and shadow[i], each holding {base, length, attr}.
  - dirty flag, set when the shadow differs from active since the last commit.
- Reset:
  - active and shadow load RstBase, RstLength and RstAttr; dirty = 0.
  - All outputs are 0.
- Match: entry i matches when length != 0 and base <= addr < base + length.
  - The sum is computed on AddrWidth+1 bits, so a region reaching the top of the address space matches up to the maximum address and does not wrap.
- Priority: the lowest matching index wins. On no match, hit = 0, attr = DefaultAttr and idx = 0.
- Lookups use the active entries only.
- Config write, field 0–2:
  - Updates shadow[idx] and sets dirty.
  - Attr writes take wdata[3:0].
  - The write is rejected (err = 1, no update) when idx >= NrRules or when active[idx].lock = 1.
- Config write, field 3 (commit):
  - Copies every shadow entry to active and clears dirty, all in the same clock edge.
  - idx is ignored.
  - Locked entries are never modified, because their shadow copy cannot change.
- Config read:
  - Fields 0–2 return the shadow value, zero-extended.
  - Field 3 returns {dirty, NrRules}, with NrRules in the low 5 bits and dirty in bit 5.
  - idx >= NrRules returns 0 with err = 1.
- Lock:
  - Setting the lock bit takes effect only at commit.
  - After commit, the entry is immutable until rst_i.

## Timing
- Lookup latency is one cycle: request in cycle N, result registered and valid in N+1.
  - There is no backpressure; every cycle accepts a new request per port.
  - Ports are fully independent; identical addresses on all ports give identical results.
- Config accesses:
  - Granted in the same cycle.
  - cfg_rvalid_o, cfg_rdata_o and cfg_err_o are registered and valid in the next cycle.
  - Back-to-back accesses are allowed every cycle.
- Commit in cycle N:
  - Lookups presented in cycle N still see the old active set.
  - Lookups presented in N+1 and later see the new set.
- A shadow write followed by a read of the same field in the next cycle returns the new value.
- rst_i asserted mid-operation:
  - Table and dirty return to their reset values on that edge.
  - All valid outputs are 0 in the following cycle.
  - In-flight lookup results are discarded.

## Test plan
- Reset with RstBase[0] = 0x8000_0000, RstLength[0] = 0x4000_0000, RstAttr[0] = 4'b0011; look up 0x8000_1000 -> next cycle hit = 1, attr = 3'b011, idx = 0; look up 0x7FFF_FFFF -> hit = 0, attr = 3'b010.
- Overlapping entries: entry 1 at 0x1000/0x1000 with attr 3'b100, entry 2 at 0x0/0x10000 with attr 3'b001; look up 0x1800 -> idx = 1, attr = 3'b100; look up 0x3000 -> idx = 2.
- Shadow and commit: write entry 0 length = 0x100 -> lookups unchanged and status read returns dirty = 1; commit in cycle N -> a lookup in N sees the old result, a lookup in N+1 sees the new one, and dirty = 0.
- Lock: write attr 4'b1001 to entry 3, commit, then write base -> err = 1 and the read-back base is unchanged; pulse rst_i -> entry 3 is writable again.
- Top-of-space: base = 0xFFFF_FFFF_FFFF_F000, length = 0x1000; look up 0xFFFF_FFFF_FFFF_FFFF -> hit = 1; look up 0x0 -> hit = 0 (no wrap).
- Multi-port plus reset: two ports issue random addresses every cycle against a reference model; assert rst_i mid-stream -> lookup_valid_o = 0 the next cycle and the table equals its reset contents.
